fifo_uart_drain: RTL and testbench
==================================

// Module: fifo_uart_drain
// PURPOSE
//  Reader end of the fifo_sync read port: pops bytes from the FIFO whenever it is
//  non-empty and enabled, and serialises each byte as an 8N1 UART frame on uart_tx.
//  Sits beside fifo_sync in the board top; FIFO contents leave the FPGA over the
//  USB-UART bridge instead of only reaching the LEDs.
// PARAMETERS
//  CLK_HZ   50_000_000  input clock frequency in Hz
//  BAUD     115200      line rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer divide, 434 at defaults)
// PORTS
//  clk            in   1  system clock; all state updates on rising edge
//  rst_n          in   1  asynchronous, active-low reset
//  enable         in   1  1 = allowed to start popping new bytes
//  fifo_empty     in   1  fifo_sync empty flag
//  fifo_r_data    in   8  fifo_sync read data, valid on the edge after fifo_rd_en
//  fifo_rd_en     out  1  one-cycle pop strobe to fifo_sync
//  uart_tx        out  1  serial line, idle high, registered
//  busy           out  1  1 whenever state != IDLE
//  byte_done      out  1  one-cycle pulse at end of each stop bit
//  bytes_sent     out 16  count of completed frames, wraps 0xFFFF->0x0000
// BEHAVIOUR
//  Reset: state=IDLE, uart_tx=1, fifo_rd_en=0, busy=0, byte_done=0, bytes_sent=0,
//   baud counter=0, bit index=0, shift register=0. Applies immediately (async).
//  FSM (Moore outputs, all registered):
//   IDLE : enable && !fifo_empty -> POP; else stay. uart_tx=1.
//   POP  : fifo_rd_en=1 for exactly this cycle -> LOAD.
//   LOAD : shift_reg <= fifo_r_data -> START; baud counter cleared.
//   START: uart_tx=0 for CLKS_PER_BIT cycles -> DATA, bit index=0.
//   DATA : uart_tx=shift_reg[0], LSB first; each CLKS_PER_BIT cycles shift right,
//          bit index++; after bit 7 -> STOP.
//   STOP : uart_tx=1 for CLKS_PER_BIT cycles; on last cycle byte_done=1 and
//          bytes_sent+1 take effect -> IDLE.
//  Latency: IDLE sampling enable&&!empty at edge N -> fifo_rd_en high cycle N+1 ->
//   uart_tx falls at edge N+3. Frame = 10*CLKS_PER_BIT cycles exactly.
//  Back-to-back: min 1 IDLE cycle between STOP and next POP; stop-to-start gap on
//   line = CLKS_PER_BIT + 3 cycles of idle-high.
//  Baud counter counts 0..CLKS_PER_BIT-1 and wraps; width = clog2(CLKS_PER_BIT).
//  Boundaries:
//   - fifo_empty only sampled in IDLE; never pops an empty FIFO.
//   - enable deasserted mid-frame: current frame completes, no further pops.
//   - fifo_empty rising mid-frame: ignored until IDLE.
//   - rst_n asserted mid-frame: line returns high immediately; popped byte is lost,
//     bytes_sent cleared.
//   - fifo_rd_en never high for more than one consecutive cycle.
// STRUCTURE
//  Shared include uart_defs.vh: state encodings (IDLE..STOP, 3-bit), frame-bit
//   constants (DATA_BITS=8, STOP_BITS=1), clog2 function.
//  One sub-module uart_tx_core: baud counter, shift register, bit index,
//   start/data/stop sequencing; ports clk, rst_n, load, din[7:0], tx, done.
//  fifo_uart_drain top: IDLE/POP/LOAD handshake FSM, bytes_sent counter.
// TESTING (sim with CLK_HZ=1000, BAUD=100 -> CLKS_PER_BIT=10, fifo_sync model)
//  1 Reset: hold rst_n=0 5 cycles -> uart_tx=1, busy=0, fifo_rd_en=0, bytes_sent=0.
//  2 Single byte 0xA5, enable=1 -> fifo_rd_en one cycle, line 0,1,0,1,0,0,1,0,1,1
//    each 10 cycles; start edge 3 cycles after empty falls; byte_done once; count=1.
//  3 Burst 0x00,0xFF,0x3C -> three frames, 13-cycle idle gaps, empty=1 after 3rd
//    pop, bytes_sent=3, no pop while empty.
//  4 enable=0 at bit 4 of frame with 2 bytes queued -> frame completes, next byte
//    stays in FIFO, busy=0; enable=1 -> second frame starts 3 cycles later.
//  5 rst_n=0 at bit 2 -> uart_tx=1 same cycle, busy=0, bytes_sent=0; after release
//    remaining FIFO bytes transmit cleanly.
//  6 Preload bytes_sent to 0xFFFF via 65535 frames (or force) -> next frame gives 0x0000.

Source files
------------

// File: rtl/fifo_uart_drain_pkg.sv
// Shared definitions for the FIFO-to-UART drain: FSM encodings, frame constants
// and a constant-width helper.
package fifo_uart_drain_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  // Handshake FSM on the FIFO side.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    POP  = 3'd1,
    LOAD = 3'd2,
    SEND = 3'd3
  } drain_e;

  // Line sequencing inside the serialiser.
  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_START = 3'd3,
    TX_DATA  = 3'd4,
    TX_STOP  = 3'd5
  } tx_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int cnt_width(input int v);
    return (clog2(v) < 1) ? 1 : clog2(v);
  endfunction

endpackage

// File: rtl/fifo_uart_drain_tx_core.sv
// 8N1 serialiser: takes a byte on load, drives start/data/stop with a
// registered line, and flags the final cycle of the last stop bit on done.
module uart_tx_core
  import fifo_uart_drain_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] din,
  output logic       tx,
  output logic       done
);

  localparam int             CW        = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0]  CNT_MAX   = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]     LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0]     LAST_STOP = 3'(STOP_BITS - 1);

  tx_e           state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_idx, bit_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          tx_nxt;
  logic          bit_end;

  assign bit_end = (cnt == CNT_MAX);
  assign done    = (state == TX_STOP) && bit_end && (bit_idx == LAST_STOP);

  // Line level is decoded from the current phase and registered, so the wire
  // trails the phase register by one cycle while every bit keeps full length.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_nxt   = bit_idx;
    shreg_nxt = shreg;
    tx_nxt    = 1'b1;
    case (state)
      TX_IDLE: begin
        if (load) begin
          shreg_nxt = din;
          cnt_nxt   = '0;
          bit_nxt   = '0;
          state_nxt = TX_START;
        end
      end
      TX_START: begin
        tx_nxt = 1'b0;
        if (bit_end) begin
          cnt_nxt   = '0;
          bit_nxt   = '0;
          state_nxt = TX_DATA;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      TX_DATA: begin
        tx_nxt = shreg[0];
        if (bit_end) begin
          cnt_nxt   = '0;
          shreg_nxt = shreg >> 1;
          if (bit_idx == LAST_DATA) begin
            bit_nxt   = '0;
            state_nxt = TX_STOP;
          end else begin
            bit_nxt = bit_idx + 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      TX_STOP: begin
        tx_nxt = 1'b1;
        if (bit_end) begin
          cnt_nxt = '0;
          if (bit_idx == LAST_STOP) begin
            bit_nxt   = '0;
            state_nxt = TX_IDLE;
          end else begin
            bit_nxt = bit_idx + 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= TX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_nxt;
      shreg   <= shreg_nxt;
      tx      <= tx_nxt;
    end
  end

endmodule

// File: rtl/fifo_uart_drain.sv
// Reader end of the sync FIFO: pops one byte at a time while enabled and
// streams it out as an 8N1 UART frame, counting completed frames.
module fifo_uart_drain
  import fifo_uart_drain_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_r_data,
  output logic        fifo_rd_en,
  output logic        uart_tx,
  output logic        busy,
  output logic        byte_done,
  output logic [15:0] bytes_sent
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

  drain_e state, state_nxt;
  logic   load;
  logic   tx_done;

  // Read data is valid one edge after the pop, which is exactly the LOAD cycle.
  assign load = (state == LOAD);

  uart_tx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_core (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .din  (fifo_r_data),
    .tx   (uart_tx),
    .done (tx_done)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable && !fifo_empty) state_nxt = POP;
      POP:     state_nxt = LOAD;
      LOAD:    state_nxt = SEND;
      SEND:    if (tx_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      fifo_rd_en <= 1'b0;
      busy       <= 1'b0;
      byte_done  <= 1'b0;
      bytes_sent <= '0;
    end else begin
      state      <= state_nxt;
      fifo_rd_en <= (state_nxt == POP);
      busy       <= (state_nxt != IDLE);
      byte_done  <= tx_done;
      if (tx_done) bytes_sent <= bytes_sent + 16'd1;
    end
  end

  rd_en_single: assert property (@(posedge clk) disable iff (!rst_n)
    fifo_rd_en |=> !fifo_rd_en);

endmodule

// File: tb/tb_fifo_uart_drain.sv
// Directed bench for fifo_uart_drain at 10 clocks per bit with a small FIFO model.
module tb_fifo_uart_drain;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        fifo_empty;
  logic [7:0]  fifo_r_data = 8'h00;
  logic        fifo_rd_en;
  logic        uart_tx;
  logic        busy;
  logic        byte_done;
  logic [15:0] bytes_sent;

  always #5 clk = ~clk;

  fifo_uart_drain #(.CLK_HZ(1000), .BAUD(100)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_r_data(fifo_r_data),
    .fifo_rd_en (fifo_rd_en),
    .uart_tx    (uart_tx),
    .busy       (busy),
    .byte_done  (byte_done),
    .bytes_sent (bytes_sent)
  );

  // FIFO model: data registered on the edge that sees the pop
  logic [7:0] mem [0:63];
  int wptr = 0;
  int rptr = 0;
  assign fifo_empty = (wptr == rptr);
  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_r_data <= mem[rptr[5:0]];
      rptr <= rptr + 1;
    end
  end

  // Line/handshake monitors
  int   done_cnt = 0, rd_cnt = 0, rd_dbl = 0, pop_empty = 0;
  int   run = 0, last_run = 0;
  logic prev_rd = 1'b0;
  always @(negedge clk) begin
    if (byte_done) done_cnt++;
    if (fifo_rd_en) rd_cnt++;
    if (fifo_rd_en && prev_rd) rd_dbl++;
    if (fifo_rd_en && fifo_empty) pop_empty++;
    prev_rd = fifo_rd_en;
    if (uart_tx) run++;
    else begin
      if (run > 0) last_run = run;
      run = 0;
    end
  end

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;  // bit i = i-th bit on the wire (start first)
    int         gap;   // expected idle-high run before start, 0 = unchecked
  } vec_t;
  vec_t vecs [9];

  int          n_chk = 0, n_fail = 0;
  logic [15:0] exp_sent = 16'h0000;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int i);
    mem[wptr[5:0]] = vecs[i].data;
    wptr = wptr + 1;
  endtask

  // Call at the cycle where the pop condition first becomes true.
  // mode 0: plain frame, 1: drop enable at bit 4, 2: reset at bit 2
  task automatic run_frame(input int i, input int mode);
    int d0, j;
    d0 = done_cnt;
    tick(); chk("rd_en_pulse", fifo_rd_en, 1); chk("done_low", byte_done, 0);
    tick(); chk("rd_en_drop", fifo_rd_en, 0);
    tick(); chk("tx_pre_start", uart_tx, 1);
    tick(); chk("start_edge", uart_tx, 0); chk("busy_frame", busy, 1);
    repeat (5) tick();
    for (int b = 0; b < 10; b++) begin
      if (b > 0) repeat (10) tick();
      chk($sformatf("v%0d_bit%0d", i, b), uart_tx, vecs[i].line[b]);
      if (b == 0 && vecs[i].gap > 0) chk("idle_gap", last_run, vecs[i].gap);
      if (mode == 1 && b == 4) enable = 1'b0;
      if (mode == 2 && b == 2) begin
        rst_n = 1'b0;
        #1;
        chk("rst_tx_high", uart_tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_count", bytes_sent, 0);
        exp_sent = 16'h0000;
        return;
      end
    end
    j = 0;
    while (!byte_done && j < 20) begin
      tick();
      j++;
    end
    chk("done_delay", j, 4);
    exp_sent = exp_sent + 16'd1;
    chk("bytes_sent", bytes_sent, exp_sent);
    chk("done_once", done_cnt - d0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{8'hA5, 10'b1101001010, 0};
    vecs[1] = '{8'h00, 10'b1000000000, 0};
    vecs[2] = '{8'hFF, 10'b1111111110, 13};
    vecs[3] = '{8'h3C, 10'b1001111000, 93};
    vecs[4] = '{8'h5A, 10'b1010110100, 0};
    vecs[5] = '{8'hC3, 10'b1110000110, 0};
    vecs[6] = '{8'h81, 10'b1100000010, 0};
    vecs[7] = '{8'h7E, 10'b1011111100, 0};
    vecs[8] = '{8'h96, 10'b1100101100, 0};

    // Reset
    rst_n = 1'b0; enable = 1'b0;
    repeat (5) tick();
    chk("reset_tx", uart_tx, 1);
    chk("reset_busy", busy, 0);
    chk("reset_rd_en", fifo_rd_en, 0);
    chk("reset_count", bytes_sent, 0);
    chk("reset_done", byte_done, 0);
    rst_n = 1'b1;
    tick();
    enable = 1'b1;
    repeat (3) tick();
    chk("empty_no_pop", fifo_rd_en, 0);
    chk("empty_idle", busy, 0);

    // Single byte
    push(0);
    run_frame(0, 0);
    repeat (3) tick();
    chk("single_idle", busy, 0);
    chk("single_pops", rd_cnt, 1);

    // Burst of three back-to-back frames
    push(1); push(2); push(3);
    for (int i = 1; i <= 3; i++) run_frame(i, 0);
    chk("burst_empty", fifo_empty, 1);
    repeat (20) tick();
    chk("burst_pops", rd_cnt, 4);
    chk("burst_idle", busy, 0);
    chk("burst_line", uart_tx, 1);

    // Enable dropped mid-frame
    push(4); push(5);
    run_frame(4, 1);
    repeat (20) tick();
    chk("dis_idle", busy, 0);
    chk("dis_line", uart_tx, 1);
    chk("dis_left", wptr - rptr, 1);
    chk("dis_pops", rd_cnt, 5);
    enable = 1'b1;
    run_frame(5, 0);
    repeat (5) tick();

    // Reset mid-frame, then the remaining byte goes out cleanly
    push(6); push(7);
    run_frame(6, 2);
    tick(); tick();
    chk("rst_hold_tx", uart_tx, 1);
    rst_n = 1'b1;
    run_frame(7, 0);
    chk("rst_after_count", bytes_sent, 1);
    repeat (5) tick();

    // Counter wrap
    force dut.bytes_sent = 16'hFFFF;
    tick();
    release dut.bytes_sent;
    tick();
    chk("preload", bytes_sent, 16'hFFFF);
    exp_sent = 16'hFFFF;
    push(8);
    run_frame(8, 0);
    chk("wrap_zero", bytes_sent, 16'h0000);

    repeat (5) tick();
    chk("rd_en_single", rd_dbl, 0);
    chk("no_empty_pop", pop_empty, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
